// File: rtl/duty_button_conditioner_if.sv
// Button/command bundle between the raw duty buttons, the sample strobe and the PWM command consumer.
interface duty_button_conditioner_if;
    logic sample_en;
    logic btn_inc_raw;
    logic btn_dec_raw;
    logic duty_inc;
    logic duty_dec;
    logic inc_level;
    logic dec_level;

    modport master (
        output sample_en, btn_inc_raw, btn_dec_raw,
        input  duty_inc, duty_dec, inc_level, dec_level
    );

    modport slave (
        input  sample_en, btn_inc_raw, btn_dec_raw,
        output duty_inc, duty_dec, inc_level, dec_level
    );
endinterface

// File: rtl/duty_button_conditioner.sv
// Synchronize, debounce and edge-detect the duty inc/dec buttons into arbitrated 1-clk command pulses.
// Optional auto-repeat while held: define DUTY_BTN_AUTO_REPEAT_EN.
module duty_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    duty_button_conditioner_if.slave    bus
);

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
            $error("duty_button_conditioner: illegal parameter value");
        end
    endgenerate

    // Bit 0 is the increase button, bit 1 the decrease button.
    logic [1:0] raw_vec;
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    logic [1:0] press_evt;
    logic [1:0] level_vec;
    logic       duty_inc_reg;
    logic       duty_dec_reg;

    assign raw_vec = {bus.btn_dec_raw, bus.btn_inc_raw};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 2'b00;
            sync2_reg <= 2'b00;
        end else begin
            sync1_reg <= raw_vec;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            state_t          state_reg;
            state_t          state_next;
            logic [CW-1:0]   cnt_reg;
            logic [CW-1:0]   cnt_next;
            logic            level_reg;
            logic            base_evt;
            logic            s;

            assign s = sync2_reg[gi];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg <= RELEASED;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    level_reg <= (state_next == PRESSED) || (state_next == CONFIRM_RELEASE);
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                base_evt   = 1'b0;
                if (bus.sample_en) begin
                    case (state_reg)
                        RELEASED: begin
                            if (s) begin
                                state_next = CONFIRM_PRESS;
                                cnt_next   = CW'(1);
                            end
                        end
                        CONFIRM_PRESS: begin
                            if (!s) begin
                                state_next = RELEASED;
                            end else if (cnt_reg == CNT_LAST) begin
                                state_next = PRESSED;
                                base_evt   = 1'b1;
                            end else begin
                                cnt_next = cnt_reg + CW'(1);
                            end
                        end
                        PRESSED: begin
                            if (!s) begin
                                state_next = CONFIRM_RELEASE;
                                cnt_next   = CW'(1);
                            end
                        end
                        CONFIRM_RELEASE: begin
                            if (s) begin
                                state_next = PRESSED;
                            end else if (cnt_reg == CNT_LAST) begin
                                state_next = RELEASED;
                            end else begin
                                cnt_next = cnt_reg + CW'(1);
                            end
                        end
                        default: begin
                            state_next = RELEASED;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

`ifdef DUTY_BTN_AUTO_REPEAT_EN
            localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RW   = $clog2(RMAX + 1);
            localparam logic [RW-1:0] DELAY_TGT  = RW'(REPEAT_DELAY);
            localparam logic [RW-1:0] PERIOD_TGT = RW'(REPEAT_PERIOD);

            logic [RW-1:0] rcnt_reg;
            logic [RW-1:0] rcnt_next;
            logic          repeated_reg;
            logic          repeated_next;
            logic          rep_fire;
            logic [RW-1:0] rcnt_inc;
            logic [RW-1:0] rep_target;

            assign rcnt_inc   = rcnt_reg + RW'(1);
            assign rep_target = repeated_reg ? PERIOD_TGT : DELAY_TGT;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rcnt_reg     <= '0;
                    repeated_reg <= 1'b0;
                end else begin
                    rcnt_reg     <= rcnt_next;
                    repeated_reg <= repeated_next;
                end
            end

            // Count only ticks spent stably in PRESSED; a release bounce freezes the count.
            always_comb begin
                rcnt_next     = rcnt_reg;
                repeated_next = repeated_reg;
                rep_fire      = 1'b0;
                if ((state_reg == CONFIRM_PRESS && state_next == PRESSED) || state_next == RELEASED) begin
                    rcnt_next     = '0;
                    repeated_next = 1'b0;
                end else if (bus.sample_en && state_reg == PRESSED && s) begin
                    if (rcnt_inc == rep_target) begin
                        rep_fire      = 1'b1;
                        rcnt_next     = '0;
                        repeated_next = 1'b1;
                    end else begin
                        rcnt_next = rcnt_inc;
                    end
                end
            end

            assign press_evt[gi] = base_evt | rep_fire;
`else
            assign press_evt[gi] = base_evt;
`endif
            assign level_vec[gi] = level_reg;
        end
    endgenerate

    // Coincident inc/dec commands cancel each other.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_inc_reg <= 1'b0;
            duty_dec_reg <= 1'b0;
        end else begin
            duty_inc_reg <= press_evt[0] & ~press_evt[1];
            duty_dec_reg <= press_evt[1] & ~press_evt[0];
        end
    end

    assign bus.duty_inc  = duty_inc_reg;
    assign bus.duty_dec  = duty_dec_reg;
    assign bus.inc_level = level_vec[0];
    assign bus.dec_level = level_vec[1];

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Randomized bench for duty_button_conditioner against a run-length debounce model of the buttons.
module tb_duty_button_conditioner;

    localparam int DC     = 4;
    localparam int RDELAY = 8;
    localparam int RPER   = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   failures  = 0;
    int   cyc       = 0;

    duty_button_conditioner_if bus_if();

    duty_button_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RDELAY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: accepted level plus length of the current run of disagreeing samples.
    int m_f1[2];
    int m_s[2];
    int m_acc[2];
    int m_run[2];
    int m_rep[2];
    int m_rep_done[2];
    int exp_pulse[2];
    int obs_pulses = 0;
    int exp_pulses = 0;

    task automatic check(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, actual, expected);
        end
    endtask

    task automatic model_step();
        int evt[2];
        int raw[2];
        int stable;
        raw[0] = int'(bus_if.btn_inc_raw);
        raw[1] = int'(bus_if.btn_dec_raw);
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                m_f1[b] = 0; m_s[b] = 0; m_acc[b] = 0; m_run[b] = 0;
                m_rep[b] = 0; m_rep_done[b] = 0; exp_pulse[b] = 0;
            end
            return;
        end
        for (int b = 0; b < 2; b++) begin
            evt[b] = 0;
            if (bus_if.sample_en) begin
                stable = (m_acc[b] == 1 && m_run[b] == 0) ? 1 : 0;
                if (m_s[b] != m_acc[b]) m_run[b]++;
                else m_run[b] = 0;
                if (m_run[b] == DC) begin
                    m_acc[b] = m_s[b];
                    m_run[b] = 0;
                    m_rep[b] = 0;
                    m_rep_done[b] = 0;
                    if (m_acc[b] == 1) evt[b] = 1;
                end
`ifdef DUTY_BTN_AUTO_REPEAT_EN
                else if (stable == 1 && m_s[b] == 1) begin
                    m_rep[b]++;
                    if (m_rep[b] == (m_rep_done[b] != 0 ? RPER : RDELAY)) begin
                        evt[b] = 1;
                        m_rep[b] = 0;
                        m_rep_done[b] = 1;
                    end
                end
`endif
            end
        end
        exp_pulse[0] = (evt[0] == 1 && evt[1] == 0) ? 1 : 0;
        exp_pulse[1] = (evt[1] == 1 && evt[0] == 0) ? 1 : 0;
        for (int b = 0; b < 2; b++) begin
            m_s[b]  = m_f1[b];
            m_f1[b] = raw[b];
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check("duty_inc",  int'(bus_if.duty_inc),  exp_pulse[0]);
        check("duty_dec",  int'(bus_if.duty_dec),  exp_pulse[1]);
        check("inc_level", int'(bus_if.inc_level), m_acc[0]);
        check("dec_level", int'(bus_if.dec_level), m_acc[1]);
        obs_pulses += int'(bus_if.duty_inc) + int'(bus_if.duty_dec);
        exp_pulses += exp_pulse[0] + exp_pulse[1];
    endtask

    int hold_left[2];
    int lvl[2];
    int first_edge;
    int pulse_cnt;
    int exp_cnt;

    initial begin
        for (int b = 0; b < 2; b++) begin
            m_f1[b] = 0; m_s[b] = 0; m_acc[b] = 0; m_run[b] = 0;
            m_rep[b] = 0; m_rep_done[b] = 0; exp_pulse[b] = 0;
            hold_left[b] = 0; lvl[b] = 0;
        end
        rst_n = 1'b0;
        bus_if.sample_en   = 1'b1;
        bus_if.btn_inc_raw = 1'b1;
        bus_if.btn_dec_raw = 1'b0;
        @(negedge clk);

        // Reset held 3 clk with the increase button already down.
        repeat (3) run_cycle();
        check("rst_outputs", int'({bus_if.duty_inc, bus_if.duty_dec, bus_if.inc_level, bus_if.dec_level}), 0);

        // Release reset before E0; button held 20 clk, pulse expected after E5.
        rst_n = 1'b1;
        first_edge = -1;
        pulse_cnt  = 0;
        for (int e = 0; e < 20; e++) begin
            run_cycle();
            if (bus_if.duty_inc) begin
                pulse_cnt++;
                if (first_edge < 0) first_edge = e;
            end
            if (e == 4) check("inc_level_pre_e5", int'(bus_if.inc_level), 0);
            if (e == 5) check("inc_level_at_e5", int'(bus_if.inc_level), 1);
        end
`ifdef DUTY_BTN_AUTO_REPEAT_EN
        exp_cnt = 3;
`else
        exp_cnt = 1;
`endif
        check("first_pulse_edge", first_edge, 5);
        check("pulse_count_held", pulse_cnt, exp_cnt);

        bus_if.btn_inc_raw = 1'b0;
        repeat (12) run_cycle();

        // Randomized buttons with glitches, varying sample rates and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            case ((n / 500) % 3)
                0: bus_if.sample_en = 1'b1;
                1: bus_if.sample_en = ((n % 4) == 0);
                default: bus_if.sample_en = 1'($urandom_range(0, 1));
            endcase
            for (int b = 0; b < 2; b++) begin
                if (hold_left[b] == 0) begin
                    lvl[b] = 1 - lvl[b];
                    hold_left[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                               : $urandom_range(4, 40);
                end
                hold_left[b]--;
            end
            bus_if.btn_inc_raw = lvl[0][0];
            bus_if.btn_dec_raw = lvl[1][0];
            if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            else if (!rst_n && $urandom_range(0, 1) == 0) rst_n = 1'b1;
            run_cycle();
        end
        rst_n = 1'b1;
        check("total_pulses", obs_pulses, exp_pulses);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
